// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO word packer: FSM state encoding,
// default geometry and the lane-index width helper.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_TIMEOUT = 16;

  // lane_cnt spans 0..LANES inclusive, hence the +1
  function automatic int lane_idx_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word valid/ready stream seen by fifo_word_packer.
// master = packer side, slave = FIFO/downstream side.
interface fifo_word_packer_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
);
  logic                   fifo_empty_i;
  logic [WIDTH-1:0]       fifo_rdata_i;
  logic                   fifo_rd_en_o;
  logic [WIDTH*LANES-1:0] m_data_o;
  logic [LANES-1:0]       m_keep_o;
  logic                   m_valid_o;
  logic                   m_ready_i;

  modport master (
    input  fifo_empty_i, fifo_rdata_i, m_ready_i,
    output fifo_rd_en_o, m_data_o, m_keep_o, m_valid_o
  );

  modport slave (
    output fifo_empty_i, fifo_rdata_i, m_ready_i,
    input  fifo_rd_en_o, m_data_o, m_keep_o, m_valid_o
  );
endinterface

// File: rtl/fifo_word_packer_lane_reg.sv
// packer_lane_reg: LANES x WIDTH lane storage with per-lane keep bits.
// A capture writes din into lane[idx]; clear zeroes data and keep.
module packer_lane_reg
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  localparam int CW   = lane_idx_w(LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cap,
  input  logic                        clr,
  input  logic [CW-1:0]               idx,
  input  logic [WIDTH-1:0]            din,
  output logic [LANES-1:0][WIDTH-1:0] data,
  output logic [LANES-1:0]            keep
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [CW-1:0] IDX = CW'(i);
    logic [WIDTH-1:0] q;
    logic             k;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        q <= '0;
        k <= 1'b0;
      end else if (clr) begin
        q <= '0;
        k <= 1'b0;
      end else if (cap && idx == IDX) begin
        q <= din;
        k <= 1'b1;
      end
    end

    assign data[i] = q;
    assign keep[i] = k;
  end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a sync FIFO, packs LANES entries per output word.
// Optional idle auto-flush is compiled in with `define PACKER_TIMEOUT_EN.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LANES   = DEF_LANES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  fifo_word_packer_if.master    bus
);

  localparam int              CW     = lane_idx_w(LANES);
  localparam logic [CW:0]     LANES_W = (CW+1)'(LANES);
  localparam logic [CW-1:0]   LAST   = CW'(LANES - 1);

  state_t                     state;
  logic [CW-1:0]              lane_cnt;
  logic                       rd_vld_q;
  logic                       flush_pend;
  logic                       m_valid;
  logic                       rd_en;
  logic                       capture;
  logic                       clr;
  logic                       flush_req;
  logic                       tmo_flush;
  logic [CW:0]                inflight;
  logic [LANES-1:0][WIDTH-1:0] lane_data;
  logic [LANES-1:0]           lane_keep;

  assign inflight = {1'b0, lane_cnt} + {{CW{1'b0}}, rd_vld_q};

  // rst_i in the term keeps the strobe low while reset is held, even if the FIFO is not empty
  assign rd_en = rst_i && (state == ST_FILL) && !bus.fifo_empty_i && !flush_pend
                 && (inflight < LANES_W);

  assign capture   = rd_vld_q && (state != ST_HOLD);
  assign clr       = (state == ST_HOLD) && m_valid && bus.m_ready_i;
  assign flush_req = flush_i || tmo_flush;

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idle_cnt <= '0;
    end else if (state != ST_FILL || capture || lane_cnt == '0) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TMO) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign tmo_flush = (state == ST_FILL) && (idle_cnt == TMO);
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
  assign tmo_flush  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_FILL;
      lane_cnt   <= '0;
      rd_vld_q   <= 1'b0;
      flush_pend <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      if (capture) lane_cnt <= lane_cnt + CW'(1);

      case (state)
        ST_FILL: begin
          if (capture && lane_cnt == LAST) begin
            state   <= ST_HOLD;
            m_valid <= 1'b1;
          end else if (flush_req && (lane_cnt != '0 || rd_vld_q)) begin
            flush_pend <= 1'b1;
            // nothing landing next cycle: the word is final now
            if (!rd_vld_q && !rd_en) begin
              state   <= ST_HOLD;
              m_valid <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // no reads issue here, so any in-flight entry lands on this edge
          state   <= ST_HOLD;
          m_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (clr) begin
            state      <= ST_FILL;
            m_valid    <= 1'b0;
            lane_cnt   <= '0;
            flush_pend <= 1'b0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  packer_lane_reg #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cap   (capture),
    .clr   (clr),
    .idx   (lane_cnt),
    .din   (bus.fifo_rdata_i),
    .data  (lane_data),
    .keep  (lane_keep)
  );

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_data_o     = lane_data;
  assign bus.m_keep_o     = lane_keep;
  assign bus.m_valid_o    = m_valid;
  assign busy_o           = (lane_cnt != '0) || rd_vld_q || m_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: FIFO model, output monitor,
// table-driven word vectors plus hand-written flush/back-pressure/reset cases.
module tb_fifo_word_packer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic flush_i = 1'b0;
  logic busy_o;

  fifo_word_packer_if #(.WIDTH(8), .LANES(4)) bus ();

  fifo_word_packer #(.WIDTH(8), .LANES(4), .TIMEOUT(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // FIFO model: tb writes mem/pushed, model owns popped
  logic [7:0] mem [0:255];
  int pushed = 0;
  int popped = 0;
  int rd_total = 0;
  int bad_rd = 0;
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];

  assign bus.fifo_empty_i = (pushed == popped);

  always @(posedge clk_i) begin
    if (bus.fifo_rd_en_o) begin
      if (bus.fifo_empty_i) bad_rd <= bad_rd + 1;
      bus.fifo_rdata_i <= mem[popped[7:0]];
      popped   <= popped + 1;
      rd_total <= rd_total + 1;
    end
    if (bus.m_valid_o && bus.m_ready_i) begin
      got_data.push_back(bus.m_data_o);
      got_keep.push_back(bus.m_keep_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[pushed[7:0]] = b;
    pushed = pushed + 1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int max_c, output int lat);
    lat = 0;
    while (!bus.m_valid_o && lat < max_c) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        flush;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[5];
  int   gi = 0;

  initial begin
    int lat;
    int rd0;

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'b1111};
    vecs[1] = '{3, 32'h00C3B2A1, 1'b1, 32'h00C3B2A1, 4'b0111};
    vecs[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001};
    vecs[3] = '{2, 32'h0000ADDE, 1'b1, 32'h0000ADDE, 4'b0011};
    vecs[4] = '{4, 32'h04030201, 1'b0, 32'h04030201, 4'b1111};

    bus.m_ready_i = 1'b1;
    #1;
    check("reset_rd_en", {31'd0, bus.fifo_rd_en_o}, 32'd0);
    check("reset_valid", {31'd0, bus.m_valid_o}, 32'd0);
    check("reset_data",  bus.m_data_o, 32'd0);
    check("reset_keep",  {28'd0, bus.m_keep_o}, 32'd0);
    check("reset_busy",  {31'd0, busy_o}, 32'd0);

    // table-driven words
    for (int v = 0; v < 5; v++) begin
      do_reset();
      rd0 = rd_total;
      for (int j = 0; j < vecs[v].n; j++) begin
        logic [31:0] w;
        w = vecs[v].bytes;
        push(w[j*8 +: 8]);
      end
      if (vecs[v].flush) begin
        for (int k = 0; k < 8; k++) tick();
        check($sformatf("v%0d_no_early_valid", v), {31'd0, bus.m_valid_o}, 32'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check($sformatf("v%0d_flush_latency", v), {31'd0, bus.m_valid_o}, 32'd1);
      end else begin
        wait_valid(20, lat);
        check($sformatf("v%0d_full_latency", v), lat, 32'd5);
      end
      for (int k = 0; k < 3; k++) tick();
      check($sformatf("v%0d_word_count", v), got_data.size(), gi + 1);
      if (got_data.size() > gi) begin
        check($sformatf("v%0d_data", v), got_data[gi], vecs[v].exp_data);
        check($sformatf("v%0d_keep", v), {28'd0, got_keep[gi]}, {28'd0, vecs[v].exp_keep});
      end
      gi = got_data.size();
      check($sformatf("v%0d_reads", v), rd_total - rd0, vecs[v].n);
      check($sformatf("v%0d_busy_idle", v), {31'd0, busy_o}, 32'd0);
    end

    // back-pressure: first word held stable, no extra reads
    do_reset();
    bus.m_ready_i = 1'b0;
    rd0 = rd_total;
    for (int j = 1; j <= 8; j++) push(8'(j));
    wait_valid(20, lat);
    check("bp_first_valid", {31'd0, bus.m_valid_o}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_data%0d", k), bus.m_data_o, 32'h04030201);
      check($sformatf("bp_hold_rd%0d", k), {31'd0, bus.fifo_rd_en_o}, 32'd0);
      tick();
    end
    check("bp_hold_reads", rd_total - rd0, 32'd4);
    check("bp_hold_keep", {28'd0, bus.m_keep_o}, 32'hF);
    bus.m_ready_i = 1'b1;
    tick();
    wait_valid(20, lat);
    check("bp_second_data", bus.m_data_o, 32'h08070605);
    for (int k = 0; k < 3; k++) tick();
    check("bp_word_count", got_data.size(), gi + 2);
    if (got_data.size() >= gi + 2) begin
      check("bp_word0", got_data[gi], 32'h04030201);
      check("bp_word1", got_data[gi+1], 32'h08070605);
    end
    gi = got_data.size();
    check("bp_reads", rd_total - rd0, 32'd8);

    // flush with FIFO empty and nothing captured: ignored
    do_reset();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("idle_flush_valid%0d", k), {31'd0, bus.m_valid_o}, 32'd0);
      check($sformatf("idle_flush_busy%0d", k), {31'd0, busy_o}, 32'd0);
      tick();
    end

    // flush while the second read is in flight
    do_reset();
    push(8'h3C);
    push(8'h7E);
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("inflight_not_yet", {31'd0, bus.m_valid_o}, 32'd0);
    tick();
    check("inflight_valid", {31'd0, bus.m_valid_o}, 32'd1);
    check("inflight_data", bus.m_data_o, 32'h00007E3C);
    check("inflight_keep", {28'd0, bus.m_keep_o}, 32'h3);
    for (int k = 0; k < 3; k++) tick();
    gi = got_data.size();

`ifdef PACKER_TIMEOUT_EN
    do_reset();
    push(8'h5A);
    wait_valid(40, lat);
    check("tmo_latency", lat, 32'd19);
    check("tmo_data", bus.m_data_o, 32'h0000005A);
    check("tmo_keep", {28'd0, bus.m_keep_o}, 32'h1);
    for (int k = 0; k < 3; k++) tick();
    gi = got_data.size();
`endif

    // asynchronous reset while a word is held
    do_reset();
    bus.m_ready_i = 1'b0;
    for (int j = 0; j < 4; j++) push(8'hA0 + 8'(j));
    wait_valid(20, lat);
    check("rst_hold_valid_before", {31'd0, bus.m_valid_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("rst_hold_valid", {31'd0, bus.m_valid_o}, 32'd0);
    check("rst_hold_keep", {28'd0, bus.m_keep_o}, 32'd0);
    check("rst_hold_data", bus.m_data_o, 32'd0);
    tick();
    rst_i = 1'b1;
    bus.m_ready_i = 1'b1;
    tick();

    check("rd_while_empty", bad_rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of the synchronous byte FIFO. It drains the FIFO's read port, packs LANES consecutive WIDTH-bit entries into one wide word, and presents that word on a valid/ready stream to the next stage. A flush request or an optional idle timeout emits a partially filled word, with a lane-keep mask marking which lanes hold data.

## Interface
- WIDTH, 8, width of one FIFO entry (one lane)
- LANES, 4, lanes per output word; power of two, ≥2
- TIMEOUT, 16, idle cycles before auto-flush (used only with the macro below)
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, asynchronous assert, active-low (0 = in reset)
- fifo_empty_i  input  1  FIFO empty flag
- fifo_rdata_i  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en_o
- fifo_rd_en_o  output  1  FIFO read strobe; never asserted while fifo_empty_i=1
- flush_i  input  1  single-cycle request to emit the current partial word
- m_data_o  output  WIDTH*LANES  packed word; lane 0 = bits [WIDTH-1:0] = oldest entry
- m_keep_o  output  LANES  lane-valid mask, contiguous from lane 0
- m_valid_o  output  1  output word valid
- m_ready_i  input  1  downstream accept
- busy_o  output  1  lane_cnt≠0, or a read is in flight, or m_valid_o=1

## Operation
- Internal state: lane_cnt (0..LANES), rd_vld_q (fifo_rd_en_o delayed by 1 cycle, meaning a read is in flight), flush_pend, FSM state.
- FSM states:
  - FILL: issue reads, capture data.
  - DRAIN: flush pending; wait for the in-flight read to land.
  - HOLD: word presented; no reads.
- fifo_rd_en_o = (state==FILL) & !fifo_empty_i & !flush_pend & (lane_cnt + rd_vld_q < LANES).
- Capture: when rd_vld_q=1, fifo_rdata_i is written into lane[lane_cnt], keep[lane_cnt]=1, and lane_cnt increments. Capture also happens in DRAIN.
- FILL→HOLD: a capture makes lane_cnt==LANES. m_valid_o rises at that same edge.
- flush_i in FILL:
  - lane_cnt=0 and rd_vld_q=0: ignored, no output.
  - Otherwise: set flush_pend and go to DRAIN.
- DRAIN→HOLD: once rd_vld_q=0 (the last capture is done). Keep equals the lanes captured.
- HOLD→FILL: on m_valid_o & m_ready_i. This clears lane_cnt, keep, lane data (to 0) and flush_pend.
- flush_i while in HOLD: ignored; the word being presented is already final.
- Unused lanes of m_data_o read as 0.
- m_data_o and m_keep_o are held stable while m_valid_o=1 & m_ready_i=0.

## Timing
- Reset values: fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, m_keep_o=0, busy_o=0; state=FILL, lane_cnt=0, rd_vld_q=0, flush_pend=0.
- Reset asserted mid-operation: all state clears immediately (asynchronous). In-flight FIFO data is discarded.
- Full-word latency: first fifo_rd_en_o in cycle N → m_valid_o high from cycle N+LANES+1, assuming FIFO never empty.
- Throughput: one word every LANES+2 cycles when m_ready_i is held high. HOLD blocks reads for one cycle.
- Flush latency:
  - No read in flight: m_valid_o is high the cycle after flush_i.
  - One read in flight: two cycles after flush_i.
- fifo_empty_i asserting mid-word: reads pause and lane_cnt holds. No output is produced without a flush.

## Configuration
- PACKER_TIMEOUT_EN defined: an idle counter runs in FILL.
  - It counts while lane_cnt>0 and no capture occurs.
  - It resets on any capture or on leaving FILL.
  - On reaching TIMEOUT it acts exactly as an internal flush_i.
- PACKER_TIMEOUT_EN undefined: no counter logic. Partial words leave only via flush_i.

## Structure
- Package fifo_pkg holds:
  - the FSM state enum (FILL, DRAIN, HOLD);
  - default WIDTH/LANES constants;
  - the lane-index width function $clog2(LANES+1).
- One natural sub-module: packer_lane_reg, the LANES×WIDTH lane register plus keep mask, with capture, clear and index inputs.
- FSM, read issue and timeout stay in the top module.

## Test plan
- Reset release, FIFO holding bytes 0x11,0x22,0x33,0x44, m_ready_i=1 → one word, m_data_o=0x44332211, m_keep_o=4'b1111, fifo_rd_en_o high for exactly 4 cycles.
- 8 bytes 0x01..0x08, m_ready_i low 5 cycles after the first valid → 0x04030201 held stable with no extra reads, then 0x08070605.
- 3 bytes 0xA1,0xB2,0xC3, then empty, then flush_i pulse → m_data_o=0x00C3B2A1, m_keep_o=4'b0111.
- flush_i with lane_cnt=0 and FIFO empty → m_valid_o stays 0, busy_o stays 0.
- flush_i in the same cycle a read is in flight → the in-flight byte is included in keep, and valid arrives two cycles after flush_i.
- With PACKER_TIMEOUT_EN, TIMEOUT=16: 1 byte 0x5A then empty → m_valid_o after 16 idle cycles, m_data_o=0x0000005A, keep=4'b0001.
- Reset asserted in HOLD → m_valid_o and m_keep_o drop to 0 immediately.
